// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: load-use stall, branch redirect/flush, halt/resume
// and saturating stall/flush cycle counters for the 5-stage CPU.
module pipe_hazard_ctrl #(
    parameter int REG_ADDR_W   = 4,
    parameter int PC_W         = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic                  ex_valid,
    input  logic                  ex_is_load,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_branch_taken,
    input  logic [PC_W-1:0]       ex_branch_pc,
    input  logic                  halt_req,
    input  logic                  resume,
    output logic                  pc_en,
    output logic                  ifid_en,
    output logic                  ifid_flush,
    output logic                  idex_bubble,
    output logic                  redirect_valid,
    output logic [PC_W-1:0]       redirect_pc,
    output logic                  halted,
    output logic [15:0]           stall_cnt,
    output logic [15:0]           flush_cnt
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES);

    state_t     state, state_nxt;
    logic [2:0] fcnt, fcnt_nxt;
    logic       load_use;
    logic       stall_inc;
    logic       flush_inc;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // A register of 0 is hardwired, so a load targeting it never creates a hazard.
    assign load_use = id_valid & ex_valid & ex_is_load & (ex_rd != '0) &
                      ((id_use_rs1 & (id_rs1 == ex_rd)) |
                       (id_use_rs2 & (id_rs2 == ex_rd)));

    always_comb begin
        pc_en          = 1'b1;
        ifid_en        = 1'b1;
        ifid_flush     = 1'b0;
        idex_bubble    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        halted         = 1'b0;
        state_nxt      = state;
        fcnt_nxt       = fcnt;
        stall_inc      = 1'b0;
        flush_inc      = 1'b0;

        if (reset) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            state_nxt   = ST_RUN;
            fcnt_nxt    = '0;
        end else if (ex_branch_taken && (state != ST_HALT)) begin
            // Redirect cycle; a branch arriving mid-flush restarts the window.
            redirect_valid = 1'b1;
            redirect_pc    = ex_branch_pc;
            ifid_flush     = 1'b1;
            idex_bubble    = 1'b1;
            state_nxt      = ST_FLUSH;
            fcnt_nxt       = FLUSH_INIT;
            flush_inc      = 1'b1;
        end else begin
            case (state)
                ST_FLUSH: begin
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                    flush_inc   = 1'b1;
                    fcnt_nxt    = fcnt - 3'd1;
                    if (fcnt <= 3'd1) begin
                        state_nxt = ST_RUN;
                        fcnt_nxt  = '0;
                    end
                end
                ST_HALT: begin
                    pc_en       = 1'b0;
                    ifid_en     = 1'b0;
                    idex_bubble = 1'b1;
                    halted      = 1'b1;
                    if (resume) begin
                        state_nxt = ST_RUN;
                    end
                end
                ST_RUN: begin
                    // A pending stall holds off the halt until the hazard clears.
                    if (load_use) begin
                        pc_en       = 1'b0;
                        ifid_en     = 1'b0;
                        idex_bubble = 1'b1;
                        stall_inc   = 1'b1;
                    end else if (halt_req) begin
                        state_nxt = ST_HALT;
                    end
                end
                default: begin
                    state_nxt = ST_RUN;
                    fcnt_nxt  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        state <= state_nxt;
        fcnt  <= fcnt_nxt;
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_inc) begin
                stall_cnt <= sat_inc(stall_cnt);
            end
            if (flush_inc) begin
                flush_cnt <= sat_inc(flush_cnt);
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: cycle-indexed reference model checked every
// cycle, plus literal expectations from the directed scenarios.
module tb_pipe_hazard_ctrl;

    localparam int REG_ADDR_W = 4;
    localparam int PC_W       = 32;
    localparam int FC         = 2;

    logic                  clock = 1'b0;
    logic                  reset = 1'b1;
    logic                  id_valid = 1'b0;
    logic [REG_ADDR_W-1:0] id_rs1 = '0;
    logic [REG_ADDR_W-1:0] id_rs2 = '0;
    logic                  id_use_rs1 = 1'b0;
    logic                  id_use_rs2 = 1'b0;
    logic                  ex_valid = 1'b0;
    logic                  ex_is_load = 1'b0;
    logic [REG_ADDR_W-1:0] ex_rd = '0;
    logic                  ex_branch_taken = 1'b0;
    logic [PC_W-1:0]       ex_branch_pc = '0;
    logic                  halt_req = 1'b0;
    logic                  resume = 1'b0;
    logic                  pc_en, ifid_en, ifid_flush, idex_bubble, redirect_valid, halted;
    logic [PC_W-1:0]       redirect_pc;
    logic [15:0]           stall_cnt, flush_cnt;

    int tests = 0;
    int fails = 0;

    pipe_hazard_ctrl #(.REG_ADDR_W(REG_ADDR_W), .PC_W(PC_W), .FLUSH_CYCLES(FC)) dut (
        .clock(clock), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_valid(ex_valid),
        .ex_is_load(ex_is_load), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
        .ex_branch_pc(ex_branch_pc), .halt_req(halt_req), .resume(resume), .pc_en(pc_en),
        .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halted(halted),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: cycle index, last flush cycle, halt flag, integer counters.
    int cyc       = 0;
    int flush_end = -1;
    bit m_halted  = 1'b0;
    int m_stall   = 0;
    int m_flush   = 0;
    bit cnt_known = 1'b0;

    always @(negedge clock) begin
        logic lu;
        logic [5:0] e; // {pc_en, ifid_en, ifid_flush, idex_bubble, redirect_valid, halted}
        logic [PC_W-1:0] e_pc;
        lu = id_valid && ex_valid && ex_is_load && ex_rd != 0 &&
             ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
        e_pc = '0;
        if (cnt_known) begin
            chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
            chk("flush_cnt", 32'(flush_cnt), 32'(m_flush));
        end
        if (reset) begin
            e = 6'b001100;
            flush_end = -1; m_halted = 0; m_stall = 0; m_flush = 0;
            cnt_known = 1'b1;
        end else if (ex_branch_taken && !m_halted) begin
            e = 6'b111110; e_pc = ex_branch_pc;
            flush_end = cyc + FC;
            m_flush = (m_flush < 65535) ? m_flush + 1 : 65535;
        end else if (cyc <= flush_end) begin
            e = 6'b111100;
            m_flush = (m_flush < 65535) ? m_flush + 1 : 65535;
        end else if (m_halted) begin
            e = 6'b000101;
            if (resume) m_halted = 0;
        end else if (lu) begin
            e = 6'b000100;
            m_stall = (m_stall < 65535) ? m_stall + 1 : 65535;
        end else begin
            e = 6'b110000;
            if (halt_req) m_halted = 1;
        end
        chk("controls", 32'({pc_en, ifid_en, ifid_flush, idex_bubble, redirect_valid, halted}),
            32'(e));
        chk("redirect_pc", redirect_pc, e_pc);
        cyc++;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Wait to mid-cycle (after the model's negedge compare) for literal checks.
    task automatic mid();
        @(negedge clock);
        #1;
    endtask

    task automatic idle();
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        ex_valid = 0; ex_is_load = 0; ex_rd = 0; ex_branch_taken = 0; ex_branch_pc = 0;
        halt_req = 0; resume = 0; reset = 0;
    endtask

    task automatic set_load_use(input logic [REG_ADDR_W-1:0] rd);
        id_valid = 1; id_use_rs2 = 1; id_rs2 = rd;
        ex_valid = 1; ex_is_load = 1; ex_rd = rd;
    endtask

    initial begin
        // Reset held for two cycles
        mid();
        chk("rst_pc_en", 32'(pc_en), 0);
        chk("rst_ifid_flush", 32'(ifid_flush), 1);
        step();
        idle();
        mid();
        chk("idle_pc_en", 32'(pc_en), 1);
        chk("idle_stall_cnt", 32'(stall_cnt), 0);
        step();

        // Load-use on rs2 = x2
        set_load_use(4'd2);
        mid();
        chk("lu_pc_en", 32'(pc_en), 0);
        chk("lu_idex_bubble", 32'(idex_bubble), 1);
        step(); idle();
        mid();
        chk("lu_stall_cnt", 32'(stall_cnt), 1);
        step();
        set_load_use(4'd0);
        mid();
        chk("x0_no_stall", 32'(pc_en), 1);
        step(); idle();

        // Branch to 0x40
        ex_branch_taken = 1; ex_branch_pc = 32'h40;
        mid();
        chk("br_redirect_valid", 32'(redirect_valid), 1);
        chk("br_redirect_pc", redirect_pc, 32'h40);
        step(); idle();
        mid(); chk("br_flush_t1", 32'(ifid_flush), 1);
        step();
        mid(); chk("br_flush_t2", 32'(ifid_flush), 1);
        step();
        mid();
        chk("br_run_flush", 32'(ifid_flush), 0);
        chk("br_run_pc_en", 32'(pc_en), 1);
        chk("br_flush_cnt", 32'(flush_cnt), 3);
        step();

        // Load-use together with a branch, then a second branch, halt held through flush
        set_load_use(4'd3);
        ex_branch_taken = 1; ex_branch_pc = 32'h100;
        mid();
        chk("lubr_pc_en", 32'(pc_en), 1);
        chk("lubr_redirect_pc", redirect_pc, 32'h100);
        step(); idle();
        ex_branch_taken = 1; ex_branch_pc = 32'h80; halt_req = 1;
        mid();
        chk("br2_redirect_pc", redirect_pc, 32'h80);
        step(); ex_branch_taken = 0; ex_branch_pc = 0;
        mid(); chk("br2_flush_t1", 32'(ifid_flush), 1);
        step();
        mid(); chk("br2_flush_t2", 32'({ifid_flush, halted}), 32'b10);
        step();
        mid(); chk("halt_deferred", 32'({pc_en, halted}), 32'b10);
        step(); halt_req = 0;
        mid(); chk("halted_on", 32'({pc_en, halted}), 32'b01);
        chk("stall_unchanged", 32'(stall_cnt), 1);
        step(); resume = 1;
        mid(); chk("resume_cycle", 32'(halted), 1);
        step(); resume = 0;
        mid(); chk("resumed", 32'({pc_en, halted}), 32'b10);
        step();

        // Halt request deferred by a load-use stall
        set_load_use(4'd5); halt_req = 1;
        mid(); chk("lu_defers_halt", 32'(pc_en), 0);
        step(); idle();
        mid(); chk("no_halt_after_lu", 32'(halted), 0);
        step();

        // Reset in the middle of a flush
        ex_branch_taken = 1; ex_branch_pc = 32'h200;
        step(); idle(); reset = 1;
        mid();
        chk("midrst_ctrl", 32'({pc_en, ifid_flush, redirect_valid}), 32'b010);
        step(); reset = 0;
        mid();
        chk("midrst_run", 32'({pc_en, ifid_flush}), 32'b10);
        chk("midrst_stall_cnt", 32'(stall_cnt), 0);
        chk("midrst_flush_cnt", 32'(flush_cnt), 0);
        step();

        // Stall counter saturation
        set_load_use(4'd7);
        repeat (65536) step();
        mid(); chk("sat_reach", 32'(stall_cnt), 32'hFFFF);
        step();
        mid(); chk("sat_hold", 32'(stall_cnt), 32'hFFFF);
        step(); idle();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
